// File: rtl/ospi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ospi_pkg
// Description : Shared opcodes, command encoding and FSM enums for the OSPI host.
// Revision    : 1.0 - initial release
// ============================================================================
package ospi_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_ERASE = 8'h20;

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_ERASE = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BEAT    = 2'd1,
        ST_CS_HOLD = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PH_CMD   = 2'd0,
        PH_ADDR  = 2'd1,
        PH_DUMMY = 2'd2,
        PH_DATA  = 2'd3
    } phase_t;

    function automatic logic [7:0] opcode_of(input logic [1:0] op);
        case (op)
            CMD_READ:  opcode_of = OP_READ;
            CMD_WRITE: opcode_of = OP_WRITE;
            default:   opcode_of = OP_ERASE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ospi_sck_gen.sv
`default_nettype none
// ============================================================================
// Module      : ospi_sck_gen
// Description : Beat timer producing OSPI_CLK plus launch and sample strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module ospi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic launch,
    output logic sample
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] c_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] c_HALF = CW'(CLK_DIV);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_sclk;

    always_comb begin
        w_cnt_nxt = '0;
        if (en && (r_cnt != c_LAST))
            w_cnt_nxt = r_cnt + 1'b1;
    end

    // Clock is registered from the next count so it never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_sclk <= en && (w_cnt_nxt >= c_HALF);
        end
    end

    assign sclk   = r_sclk;
    assign launch = en && (r_cnt == '0);
    assign sample = en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/ospi_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ospi_host_ctrl
// Description : Octal-SPI SDR host; read/write/erase requests to OSPI bus beats.
//               Optional read dummy beats enabled by OSPI_HOST_DUMMY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ospi_host_ctrl
    import ospi_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_addr,
    input  logic [WIDTH-1:0] cmd_wdata,
`ifdef OSPI_HOST_DUMMY_EN
    input  logic [3:0]       dummy_cycles,
`endif
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] rdata,
    output logic             OSPI_CLK,
    output logic             OSPI_CS,
    output logic [7:0]       OSPI_IO_O,
    output logic             OSPI_IO_OE,
    input  logic [7:0]       OSPI_IO_I
);

    localparam int HW = $clog2(CLK_DIV + 1);

    state_t           r_state;
    phase_t           r_phase;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_rdata;
    logic [3:0]       r_dcnt;
    logic [HW-1:0]    r_hold;
    logic             r_ready, r_done, r_err, r_cs, r_oe;
    logic [7:0]       r_io_o;
    logic [3:0]       w_dummy;
    logic             w_sclk, w_launch, w_sample;

`ifdef OSPI_HOST_DUMMY_EN
    logic [3:0] r_dummy;
    always_ff @(posedge clk) begin
        if (reset)
            r_dummy <= 4'd0;
        else if ((r_state == ST_IDLE) && cmd_valid)
            r_dummy <= dummy_cycles;
    end
    assign w_dummy = r_dummy;
`else
    assign w_dummy = 4'd0;
`endif

    ospi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk    (clk),
        .reset  (reset),
        .en     (r_state == ST_BEAT),
        .sclk   (w_sclk),
        .launch (w_launch),
        .sample (w_sample)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_phase <= PH_CMD;
            r_op    <= CMD_READ;
            r_addr  <= '0;
            r_wdata <= '0;
            r_shift <= '0;
            r_rdata <= '0;
            r_dcnt  <= 4'd0;
            r_hold  <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cs    <= 1'b1;
            r_oe    <= 1'b0;
            r_io_o  <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_addr  <= cmd_addr;
                        r_wdata <= cmd_wdata;
                        r_ready <= 1'b0;
                        if (cmd_op == CMD_RSVD) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= ST_BEAT;
                            r_phase <= PH_CMD;
                            r_cs    <= 1'b0;
                            r_oe    <= 1'b1;
                            r_io_o  <= opcode_of(cmd_op);
                        end
                    end
                end
                ST_BEAT: begin
                    if (w_launch && (r_phase == PH_DUMMY))
                        r_dcnt <= r_dcnt - 1'b1;
                    // Bus values registered here appear at the next beat start.
                    if (w_sample) begin
                        case (r_phase)
                            PH_CMD: begin
                                r_phase <= PH_ADDR;
                                r_io_o  <= r_addr;
                            end
                            PH_ADDR: begin
                                r_io_o <= 8'h00;
                                r_oe   <= 1'b0;
                                if (r_op == CMD_ERASE) begin
                                    r_state <= ST_CS_HOLD;
                                    r_hold  <= HW'(CLK_DIV - 1);
                                end else if (r_op == CMD_READ) begin
                                    r_phase <= (w_dummy != 4'd0) ? PH_DUMMY : PH_DATA;
                                    r_dcnt  <= w_dummy;
                                end else begin
                                    r_phase <= PH_DATA;
                                    r_io_o  <= r_wdata;
                                    r_oe    <= 1'b1;
                                end
                            end
                            PH_DUMMY: begin
                                if (r_dcnt == 4'd0)
                                    r_phase <= PH_DATA;
                            end
                            PH_DATA: begin
                                if (r_op == CMD_READ)
                                    r_shift <= OSPI_IO_I;
                                r_state <= ST_CS_HOLD;
                                r_hold  <= HW'(CLK_DIV - 1);
                                r_io_o  <= 8'h00;
                                r_oe    <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_CS_HOLD: begin
                    if (r_hold == '0) begin
                        r_state <= ST_DONE;
                        r_cs    <= 1'b1;
                        r_done  <= 1'b1;
                        if (r_op == CMD_READ)
                            r_rdata <= r_shift;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready  = r_ready;
    assign done       = r_done;
    assign err        = r_err;
    assign rdata      = r_rdata;
    assign OSPI_CLK   = w_sclk;
    assign OSPI_CS    = r_cs;
    assign OSPI_IO_O  = r_io_o;
    assign OSPI_IO_OE = r_oe;

endmodule
`default_nettype wire
